// File: rtl/sbuf_console.sv
`default_nettype none
// ============================================================================
// Module : sbuf_console
// Brief  : Terminal-style sequencer that owns the screen-buffer CPU port.
// Rev    : 1.0
// ============================================================================
module sbuf_console #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 25,
  parameter int         STRIDE   = 128,
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset_,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        busy,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        sbuf_wr,
  output logic        sbuf_rd,
  output logic [11:0] sbuf_addr,
  output logic [7:0]  sbuf_wdata,
  input  logic [7:0]  sbuf_rdata
);

  localparam int unsigned c_SHIFT  = $clog2(STRIDE);
  localparam logic [6:0]  c_X_LAST = 7'(COLS - 1);
  localparam logic [4:0]  c_Y_LAST = 5'(ROWS - 1);
  localparam logic [7:0]  c_BS     = 8'h08;
  localparam logic [7:0]  c_LF     = 8'h0A;
  localparam logic [7:0]  c_FF     = 8'h0C;
  localparam logic [7:0]  c_CR     = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_CLEAR      = 3'd2,
    S_SCROLL_RD  = 3'd3,
    S_SCROLL_WR  = 3'd4,
    S_SCROLL_CLR = 3'd5
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_cx, w_cx_nxt;
  logic [4:0] r_cy, w_cy_nxt;
  logic [6:0] r_ox, w_ox_nxt;
  logic [4:0] r_oy, w_oy_nxt;
  logic [7:0] r_byte, w_byte_nxt;
  logic       w_accept;
  logic       w_lf;
  logic       w_op_last_x;

  function automatic logic [11:0] f_addr(input logic [4:0] y, input logic [6:0] x);
    return (12'(y) << c_SHIFT) + 12'(x);
  endfunction

  assign cursor_x = r_cx;
  assign cursor_y = r_cy;

  always_ff @(posedge cpu_clk or negedge cpu_reset_) begin
    if (!cpu_reset_) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_ox    <= w_ox_nxt;
      r_oy    <= w_oy_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    w_byte_nxt  = r_byte;
    w_lf        = 1'b0;
    // Gating with the reset keeps the source from seeing ready while held in reset.
    char_ready  = (r_state == S_IDLE) && cpu_reset_;
    busy        = 1'b0;
    sbuf_wr     = 1'b0;
    sbuf_rd     = 1'b0;
    sbuf_addr   = '0;
    sbuf_wdata  = '0;
    w_accept    = char_valid && char_ready;
    w_op_last_x = (r_ox == c_X_LAST);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (char_data)
            c_BS: if (r_cx != 7'd0) w_cx_nxt = r_cx - 7'd1;
            c_CR: w_cx_nxt = '0;
            c_LF: w_lf = 1'b1;
            c_FF: begin
              w_state_nxt = S_CLEAR;
              w_cx_nxt    = '0;
              w_cy_nxt    = '0;
              w_ox_nxt    = '0;
              w_oy_nxt    = '0;
            end
            default: begin
              w_state_nxt = S_WRITE;
              w_byte_nxt  = char_data;
            end
          endcase
        end
      end

      S_WRITE: begin
        sbuf_wr     = 1'b1;
        sbuf_addr   = f_addr(r_cy, r_cx);
        sbuf_wdata  = r_byte;
        w_state_nxt = S_IDLE;
        if (r_cx == c_X_LAST) w_lf = 1'b1;
        else                  w_cx_nxt = r_cx + 7'd1;
      end

      S_CLEAR: begin
        busy       = 1'b1;
        sbuf_wr    = 1'b1;
        sbuf_addr  = f_addr(r_oy, r_ox);
        sbuf_wdata = CLR_CHAR;
        if (w_op_last_x) begin
          w_ox_nxt = '0;
          if (r_oy == c_Y_LAST) w_state_nxt = S_IDLE;
          else                  w_oy_nxt    = r_oy + 5'd1;
        end else begin
          w_ox_nxt = r_ox + 7'd1;
        end
      end

      S_SCROLL_RD: begin
        busy        = 1'b1;
        sbuf_rd     = 1'b1;
        sbuf_addr   = f_addr(r_oy, r_ox);
        w_state_nxt = S_SCROLL_WR;
      end

      // Read data returns one cycle late, so it is forwarded straight to the row above.
      S_SCROLL_WR: begin
        busy        = 1'b1;
        sbuf_wr     = 1'b1;
        sbuf_addr   = f_addr(r_oy - 5'd1, r_ox);
        sbuf_wdata  = sbuf_rdata;
        w_state_nxt = S_SCROLL_RD;
        if (w_op_last_x) begin
          w_ox_nxt = '0;
          if (r_oy == c_Y_LAST) w_state_nxt = S_SCROLL_CLR;
          else                  w_oy_nxt    = r_oy + 5'd1;
        end else begin
          w_ox_nxt = r_ox + 7'd1;
        end
      end

      S_SCROLL_CLR: begin
        busy       = 1'b1;
        sbuf_wr    = 1'b1;
        sbuf_addr  = f_addr(c_Y_LAST, r_ox);
        sbuf_wdata = CLR_CHAR;
        if (w_op_last_x) w_state_nxt = S_IDLE;
        else             w_ox_nxt    = r_ox + 7'd1;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Line feed, either explicit or from wrapping past the last column.
    if (w_lf) begin
      w_cx_nxt = '0;
      if (r_cy < c_Y_LAST) begin
        w_cy_nxt = r_cy + 5'd1;
      end else begin
        w_state_nxt = (ROWS > 1) ? S_SCROLL_RD : S_SCROLL_CLR;
        w_ox_nxt    = '0;
        w_oy_nxt    = 5'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbuf_console.sv
`default_nettype none
// Directed self-checking bench for sbuf_console with a 1-cycle registered buffer model.
module tb_sbuf_console;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset_;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        busy;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        sbuf_wr;
  logic        sbuf_rd;
  logic [11:0] sbuf_addr;
  logic [7:0]  sbuf_wdata;
  logic [7:0]  sbuf_rdata = 8'h00;

  logic [7:0]  mem [0:4095];
  logic [1:0]  fill_mode;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  sbuf_console dut (
    .cpu_clk    (cpu_clk),
    .cpu_reset_ (cpu_reset_),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .busy       (busy),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .sbuf_wr    (sbuf_wr),
    .sbuf_rd    (sbuf_rd),
    .sbuf_addr  (sbuf_addr),
    .sbuf_wdata (sbuf_wdata),
    .sbuf_rdata (sbuf_rdata)
  );

  // Buffer model: mode 1 fills 0xEE, mode 2 fills every byte with its row number.
  always @(posedge cpu_clk) begin
    if (fill_mode == 2'd1) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'hEE;
    end else if (fill_mode == 2'd2) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'(a >> 7);
    end else if (sbuf_wr) begin
      mem[sbuf_addr] <= sbuf_wdata;
    end
    if (sbuf_rd) sbuf_rdata <= mem[sbuf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    if (n == 5000) chk("ready_timeout", char_ready, 1);
    char_valid = 1'b1;
    char_data  = b;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic putc(input logic [7:0] b);
    send(b);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad, exp_a, p, src, n;
    logic ok, acc;
    logic [11:0] a0, a1, a79, a80, alast;
    logic [7:0]  d1;

    cpu_reset_ = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    fill_mode  = 2'd1;
    tick();
    fill_mode = 2'd0;
    tick();

    // Reset state
    chk("rst_wr", sbuf_wr, 0);
    chk("rst_rd", sbuf_rd, 0);
    chk("rst_addr", sbuf_addr, 0);
    chk("rst_wdata", sbuf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", {cursor_y, cursor_x}, 0);
    cpu_reset_ = 1'b1;
    #1;
    chk("ready_after_rst", char_ready, 1);
    tick();

    // Single printable byte
    send(8'h41);
    chk("p_wr", sbuf_wr, 1);
    chk("p_addr", sbuf_addr, 0);
    chk("p_wdata", sbuf_wdata, 8'h41);
    chk("p_busy", busy, 0);
    chk("p_ready", char_ready, 0);
    tick();
    chk("p_cx", cursor_x, 1);
    chk("p_cy", cursor_y, 0);
    chk("p_ready_back", char_ready, 1);
    chk("p_wr_idle", sbuf_wr, 0);

    // Ten back-to-back bytes in 20 cycles
    n = 0;
    char_valid = 1'b1;
    char_data  = 8'h30;
    for (int c = 0; c < 20; c++) begin
      acc = char_ready;
      tick();
      if (acc) begin
        n++;
        char_data = 8'(8'h30 + n);
      end
    end
    char_valid = 1'b0;
    chk("b2b_count", n, 10);
    chk("b2b_cx", cursor_x, 11);
    chk("b2b_mem1", mem[1], 8'h30);
    chk("b2b_mem10", mem[10], 8'h39);

    // Line wrap, BS, CR
    for (int i = 0; i < 3; i++) send(8'h0A);
    chk("lf_cy", cursor_y, 3);
    chk("lf_cx", cursor_x, 0);
    for (int i = 0; i < 79; i++) putc(8'h61);
    chk("pre_wrap_cx", cursor_x, 79);
    send(8'h42);
    chk("wrap_wr", sbuf_wr, 1);
    chk("wrap_addr", sbuf_addr, 12'h1CF);
    chk("wrap_wdata", sbuf_wdata, 8'h42);
    tick();
    chk("wrap_cursor", {cursor_y, cursor_x}, {5'd4, 7'd0});
    send(8'h08);
    chk("bs0_wr", sbuf_wr, 0);
    chk("bs0_cursor", {cursor_y, cursor_x}, {5'd4, 7'd0});
    for (int i = 0; i < 5; i++) putc(8'h62);
    send(8'h08);
    chk("bs_cx", cursor_x, 4);
    send(8'h0D);
    chk("cr_cursor", {cursor_y, cursor_x}, {5'd4, 7'd0});

    // Full-screen clear
    send(8'h0C);
    bad = 0;
    a0 = '1; a79 = '1; a80 = '1; alast = '1;
    for (int k = 0; k < 2000; k++) begin
      exp_a = (k / 80) * 128 + k % 80;
      ok = (sbuf_wr === 1'b1) && (sbuf_rd === 1'b0) && (sbuf_addr === 12'(exp_a)) &&
           (sbuf_wdata === 8'h20) && (busy === 1'b1) && (char_ready === 1'b0);
      if (!ok) bad++;
      if (k == 0)    a0    = sbuf_addr;
      if (k == 79)   a79   = sbuf_addr;
      if (k == 80)   a80   = sbuf_addr;
      if (k == 1999) alast = sbuf_addr;
      tick();
    end
    chk("clr_bad_cycles", bad, 0);
    chk("clr_first", a0, 0);
    chk("clr_79", a79, 79);
    chk("clr_80", a80, 128);
    chk("clr_last", alast, 3151);
    chk("clr_busy_end", busy, 0);
    chk("clr_ready_end", char_ready, 1);
    chk("clr_cursor", {cursor_y, cursor_x}, 0);
    chk("clr_mem0", mem[0], 8'h20);
    chk("clr_mem3151", mem[3151], 8'h20);
    chk("clr_untouched80", mem[80], 8'hEE);
    chk("clr_untouched3152", mem[3152], 8'hEE);

    // Scroll from the last row
    for (int i = 0; i < 24; i++) send(8'h0A);
    for (int i = 0; i < 3; i++) putc(8'h18);
    chk("scr_pre_cursor", {cursor_y, cursor_x}, {5'd24, 7'd3});
    fill_mode = 2'd2;
    tick();
    fill_mode = 2'd0;
    send(8'h0A);
    bad = 0;
    a0 = '1; a1 = '1; d1 = '1;
    for (int k = 0; k < 3920; k++) begin
      if (k < 3840) begin
        p   = k / 2;
        src = (1 + p / 80) * 128 + p % 80;
        if (k % 2 == 0)
          ok = (sbuf_rd === 1'b1) && (sbuf_wr === 1'b0) && (sbuf_addr === 12'(src));
        else
          ok = (sbuf_wr === 1'b1) && (sbuf_rd === 1'b0) && (sbuf_addr === 12'(src - 128)) &&
               (sbuf_wdata === 8'(1 + p / 80));
      end else begin
        ok = (sbuf_wr === 1'b1) && (sbuf_rd === 1'b0) &&
             (sbuf_addr === 12'(3072 + k - 3840)) && (sbuf_wdata === 8'h20);
      end
      if (!(ok && busy === 1'b1 && char_ready === 1'b0)) bad++;
      if (k == 0) a0 = sbuf_addr;
      if (k == 1) begin
        a1 = sbuf_addr;
        d1 = sbuf_wdata;
      end
      tick();
    end
    chk("scr_bad_cycles", bad, 0);
    chk("scr_rd0_addr", a0, 128);
    chk("scr_wr0_addr", a1, 0);
    chk("scr_wr0_data", d1, 8'h01);
    chk("scr_busy_end", busy, 0);
    chk("scr_cursor", {cursor_y, cursor_x}, {5'd24, 7'd0});
    chk("scr_row0", mem[0], 8'h01);
    chk("scr_row0_79", mem[79], 8'h01);
    chk("scr_row23", mem[23 * 128 + 5], 8'h18);
    chk("scr_row24_first", mem[3072], 8'h20);
    chk("scr_row24_last", mem[3151], 8'h20);

    // Reset in the middle of a scroll
    fill_mode = 2'd2;
    tick();
    fill_mode = 2'd0;
    send(8'h0A);
    for (int k = 0; k < 1000; k++) tick();
    chk("mid_rd", sbuf_rd, 1);
    chk("mid_addr", sbuf_addr, 7 * 128 + 20);
    #2;
    cpu_reset_ = 1'b0;
    #1;
    chk("mid_rst_wr", sbuf_wr, 0);
    chk("mid_rst_rd", sbuf_rd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", sbuf_addr, 0);
    chk("mid_rst_cursor", {cursor_y, cursor_x}, 0);
    tick();
    cpu_reset_ = 1'b1;
    chk("mid_row0", mem[0], 8'h01);
    chk("mid_r6c19", mem[6 * 128 + 19], 8'h07);
    chk("mid_r6c20", mem[6 * 128 + 20], 8'h06);
    send(8'h41);
    chk("post_wr", sbuf_wr, 1);
    chk("post_addr", sbuf_addr, 0);
    chk("post_wdata", sbuf_wdata, 8'h41);
    tick();
    chk("post_mem0", mem[0], 8'h41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
